// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency, single-ported memory between the fetch port and the load/store port.
// Also handles store lane steering and write strobes, and sign/zero extension of loads.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_DBURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [31:0]           i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [2:0]            d_addrmode,
  input  logic [31:0]           d_wdata,
  output logic                  d_ack,
  output logic [31:0]           d_rdata,
  output logic                  d_misalign,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0]            MAXB      = 4'(MAX_DBURST);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  state_t                state_q, state_d;
  logic [3:0]            dstreak_q, dstreak_d;
  logic                  port_q, port_d;
  logic [2:0]            mode_q, mode_d;
  logic [1:0]            lo_q, lo_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_wstrb_q, mem_wstrb_d;
  logic                  i_ack_q, i_ack_d;
  logic [31:0]           i_rdata_q, i_rdata_d;
  logic                  d_ack_q, d_ack_d;
  logic [31:0]           d_rdata_q, d_rdata_d;
  logic                  d_misalign_q, d_misalign_d;
  logic                  data_wins;

  function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] lo);
    case (mode)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return lo[0];
      3'b010:         return lo != 2'b00;
      default:        return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] steer_wdata(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] steer_wstrb(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] mode, input logic [1:0] lo,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (mode)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  // Data belongs to the older instruction, so it wins unless fetch has waited a full burst.
  assign data_wins = d_req && !(i_req && (dstreak_q == MAXB));

  always_comb begin
    state_d      = state_q;
    dstreak_d    = dstreak_q;
    port_d       = port_q;
    mode_d       = mode_q;
    lo_d         = lo_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    i_ack_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_ack_d      = 1'b0;
    d_rdata_d    = d_rdata_q;
    d_misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_wins) begin
          if (i_req) dstreak_d = (dstreak_q >= MAXB) ? MAXB : dstreak_q + 4'd1;
          else       dstreak_d = 4'd0;
          if (is_misaligned(d_addrmode, d_addr[1:0])) begin
            state_d      = RESP;
            d_ack_d      = 1'b1;
            d_misalign_d = 1'b1;
            d_rdata_d    = 32'h0;
          end else begin
            state_d     = BUSY;
            port_d      = 1'b1;
            mode_d      = d_addrmode;
            lo_d        = d_addr[1:0];
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr & WORD_MASK;
            mem_wdata_d = steer_wdata(d_addrmode[1:0], d_wdata);
            mem_wstrb_d = d_we ? steer_wstrb(d_addrmode[1:0], d_addr[1:0]) : 4'b0000;
          end
        end else if (i_req) begin
          dstreak_d   = 4'd0;
          state_d     = BUSY;
          port_d      = 1'b0;
          mode_d      = 3'b010;
          lo_d        = 2'b00;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr & WORD_MASK;
          mem_wdata_d = 32'h0;
          mem_wstrb_d = 4'b0000;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d     = RESP;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          if (port_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = load_ext(mode_q, lo_q, mem_rdata);
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dstreak_q    <= 4'd0;
      port_q       <= 1'b0;
      mode_q       <= 3'b000;
      lo_q         <= 2'b00;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      mem_wstrb_q  <= 4'b0000;
      i_ack_q      <= 1'b0;
      i_rdata_q    <= 32'h0;
      d_ack_q      <= 1'b0;
      d_rdata_q    <= 32'h0;
      d_misalign_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dstreak_q    <= dstreak_d;
      port_q       <= port_d;
      mode_q       <= mode_d;
      lo_q         <= lo_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      i_ack_q      <= i_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_ack_q      <= d_ack_d;
      d_rdata_q    <= d_rdata_d;
      d_misalign_q <= d_misalign_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign i_ack      = i_ack_q;
  assign i_rdata    = i_rdata_q;
  assign d_ack      = d_ack_q;
  assign d_rdata    = d_rdata_q;
  assign d_misalign = d_misalign_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, stores, loads, misalign, starvation, reset mid-cycle.
module tb_mem_port_arbiter;
  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [2:0]  d_addrmode;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_ready_man;
  logic        mem_auto;

  int total = 0;
  int bad = 0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .MAX_DBURST(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_addrmode(d_addrmode),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_misalign(d_misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // Zero-wait-state responder when mem_auto is set, otherwise driven by hand.
  assign mem_ready = mem_auto ? mem_req : mem_ready_man;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic d_access(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdat,
                          output logic [31:0] o_maddr, output logic [31:0] o_mwdata,
                          output logic [3:0] o_wstrb, output logic o_mwe,
                          output logic [31:0] o_rdata, output logic o_mis,
                          output int o_ack_cyc, output logic o_req_seen);
    o_maddr = 0; o_mwdata = 0; o_wstrb = 0; o_mwe = 0; o_rdata = 0; o_mis = 0;
    o_ack_cyc = 0; o_req_seen = 0;
    d_req = 1'b1; d_we = we; d_addrmode = mode; d_addr = addr; d_wdata = wdata;
    step();
    o_req_seen = mem_req;
    if (d_ack) begin
      o_ack_cyc = 1; o_rdata = d_rdata; o_mis = d_misalign;
      d_req = 1'b0;
      step();
      o_req_seen = o_req_seen | mem_req;
    end else begin
      o_maddr = mem_addr; o_mwdata = mem_wdata; o_wstrb = mem_wstrb; o_mwe = mem_we;
      mem_ready_man = 1'b1; mem_rdata = rdat;
      step();
      mem_ready_man = 1'b0;
      if (d_ack) begin
        o_ack_cyc = 2; o_rdata = d_rdata; o_mis = d_misalign;
      end
      d_req = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    total++;
    if ({mem_req, mem_we, mem_wstrb, i_ack, d_ack, d_misalign} !== 9'h0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0", {mem_req, mem_we, mem_wstrb, i_ack, d_ack, d_misalign});
    end
    total++;
    if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    total++;
    if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    total++;
    if (i_rdata !== 32'h0) begin bad++; $display("FAIL reset_i_rdata: got %h want 0", i_rdata); end
    total++;
    if (d_rdata !== 32'h0) begin bad++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
  endtask

  task automatic test_fetch();
    i_req = 1'b1; i_addr = 32'h100;
    step();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      bad++; $display("FAIL fetch_req: got req=%b addr=%h want 1 00000100", mem_req, mem_addr);
    end
    total++;
    if (mem_wstrb !== 4'b0000 || mem_we !== 1'b0) begin
      bad++; $display("FAIL fetch_wstrb: got we=%b wstrb=%b want 0 0000", mem_we, mem_wstrb);
    end
    step();
    total++;
    if (i_ack !== 1'b0 || mem_req !== 1'b1) begin
      bad++; $display("FAIL fetch_wait: got ack=%b req=%b want 0 1", i_ack, mem_req);
    end
    mem_ready_man = 1'b1; mem_rdata = 32'h00A00093;
    step();
    mem_ready_man = 1'b0;
    total++;
    if (i_ack !== 1'b1 || i_rdata !== 32'h00A00093) begin
      bad++; $display("FAIL fetch_ack: got ack=%b rdata=%h want 1 00a00093", i_ack, i_rdata);
    end
    total++;
    if (mem_req !== 1'b0 || d_ack !== 1'b0) begin
      bad++; $display("FAIL fetch_resp: got mem_req=%b d_ack=%b want 0 0", mem_req, d_ack);
    end
    step();
    total++;
    if (i_ack !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL fetch_no_double: got ack=%b req=%b want 0 0", i_ack, mem_req);
    end
    i_req = 1'b0;
  endtask

  task automatic test_stores();
    logic [31:0] ma, mw, rd;
    logic [3:0]  ws;
    logic        we, mis, seen;
    int          ac;
    d_access(1'b1, 3'b000, 32'h203, 32'h000000AB, 32'h0, ma, mw, ws, we, rd, mis, ac, seen);
    total++;
    if (mw !== 32'hABABABAB || ws !== 4'b1000 || ma !== 32'h200 || we !== 1'b1) begin
      bad++; $display("FAIL sb: got wdata=%h wstrb=%b addr=%h we=%b want abababab 1000 00000200 1", mw, ws, ma, we);
    end
    total++;
    if (ac !== 2 || mis !== 1'b0) begin bad++; $display("FAIL sb_ack: got cycle=%0d mis=%b want 2 0", ac, mis); end
    d_access(1'b1, 3'b001, 32'h202, 32'h00001234, 32'h0, ma, mw, ws, we, rd, mis, ac, seen);
    total++;
    if (mw !== 32'h12341234 || ws !== 4'b1100 || ma !== 32'h200) begin
      bad++; $display("FAIL sh: got wdata=%h wstrb=%b addr=%h want 12341234 1100 00000200", mw, ws, ma);
    end
    d_access(1'b1, 3'b001, 32'h200, 32'h0000BEEF, 32'h0, ma, mw, ws, we, rd, mis, ac, seen);
    total++;
    if (mw !== 32'hBEEFBEEF || ws !== 4'b0011) begin
      bad++; $display("FAIL sh_lo: got wdata=%h wstrb=%b want beefbeef 0011", mw, ws);
    end
    d_access(1'b1, 3'b010, 32'h204, 32'hDEADBEEF, 32'h0, ma, mw, ws, we, rd, mis, ac, seen);
    total++;
    if (mw !== 32'hDEADBEEF || ws !== 4'b1111 || ma !== 32'h204) begin
      bad++; $display("FAIL sw: got wdata=%h wstrb=%b addr=%h want deadbeef 1111 00000204", mw, ws, ma);
    end
  endtask

  task automatic test_loads();
    logic [31:0] ma, mw, rd;
    logic [3:0]  ws;
    logic        we, mis, seen;
    int          ac;
    d_access(1'b0, 3'b000, 32'h3, 32'h0, 32'h80FF7F01, ma, mw, ws, we, rd, mis, ac, seen);
    total++;
    if (rd !== 32'hFFFFFF80 || ac !== 2) begin bad++; $display("FAIL lb: got %h cycle=%0d want ffffff80 2", rd, ac); end
    total++;
    if (ws !== 4'b0000 || we !== 1'b0) begin bad++; $display("FAIL lb_wstrb: got %b we=%b want 0000 0", ws, we); end
    d_access(1'b0, 3'b100, 32'h3, 32'h0, 32'h80FF7F01, ma, mw, ws, we, rd, mis, ac, seen);
    total++;
    if (rd !== 32'h00000080) begin bad++; $display("FAIL lbu: got %h want 00000080", rd); end
    d_access(1'b0, 3'b001, 32'h2, 32'h0, 32'h80FF7F01, ma, mw, ws, we, rd, mis, ac, seen);
    total++;
    if (rd !== 32'hFFFF80FF) begin bad++; $display("FAIL lh: got %h want ffff80ff", rd); end
    d_access(1'b0, 3'b101, 32'h0, 32'h0, 32'h80FF7F01, ma, mw, ws, we, rd, mis, ac, seen);
    total++;
    if (rd !== 32'h00007F01) begin bad++; $display("FAIL lhu: got %h want 00007f01", rd); end
    d_access(1'b0, 3'b000, 32'h1, 32'h0, 32'h80FF7F01, ma, mw, ws, we, rd, mis, ac, seen);
    total++;
    if (rd !== 32'h0000007F) begin bad++; $display("FAIL lb_pos: got %h want 0000007f", rd); end
    d_access(1'b0, 3'b010, 32'h8, 32'h0, 32'h80FF7F01, ma, mw, ws, we, rd, mis, ac, seen);
    total++;
    if (rd !== 32'h80FF7F01 || mis !== 1'b0) begin bad++; $display("FAIL lw: got %h mis=%b want 80ff7f01 0", rd, mis); end
    total++;
    if (i_rdata !== 32'h00A00093) begin bad++; $display("FAIL i_rdata_hold: got %h want 00a00093", i_rdata); end
  endtask

  task automatic test_misalign();
    logic [31:0] ma, mw, rd;
    logic [3:0]  ws;
    logic        we, mis, seen;
    int          ac;
    d_access(1'b0, 3'b010, 32'h102, 32'h0, 32'h11111111, ma, mw, ws, we, rd, mis, ac, seen);
    total++;
    if (ac !== 1 || mis !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL lw_misalign: got cycle=%0d mis=%b rdata=%h want 1 1 0", ac, mis, rd);
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL lw_misalign_memreq: got %b want 0", seen); end
    d_access(1'b1, 3'b001, 32'h101, 32'h1234, 32'h11111111, ma, mw, ws, we, rd, mis, ac, seen);
    total++;
    if (ac !== 1 || mis !== 1'b1 || seen !== 1'b0) begin
      bad++; $display("FAIL sh_misalign: got cycle=%0d mis=%b memreq=%b want 1 1 0", ac, mis, seen);
    end
    d_access(1'b0, 3'b011, 32'h100, 32'h0, 32'h11111111, ma, mw, ws, we, rd, mis, ac, seen);
    total++;
    if (ac !== 1 || mis !== 1'b1 || seen !== 1'b0) begin
      bad++; $display("FAIL mode011: got cycle=%0d mis=%b memreq=%b want 1 1 0", ac, mis, seen);
    end
    total++;
    if (d_ack !== 1'b0 || d_misalign !== 1'b0) begin
      bad++; $display("FAIL misalign_pulse: got ack=%b mis=%b want 0 0", d_ack, d_misalign);
    end
  endtask

  task automatic test_starvation();
    logic [9:0] seq;
    int         n;
    seq = '0; n = 0;
    mem_auto = 1'b1; mem_rdata = 32'h0;
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addrmode = 3'b010; d_addr = 32'h400;
    for (int c = 0; c < 200 && n < 10; c++) begin
      step();
      if (d_ack) begin seq = {seq[8:0], 1'b1}; n++; end
      else if (i_ack) begin seq = {seq[8:0], 1'b0}; n++; end
    end
    i_req = 1'b0;
    total++;
    if (seq !== 10'b1111011110 || n != 10) begin
      bad++; $display("FAIL grant_order: got %b (%0d grants) want 1111011110 (1=D)", seq, n);
    end
    n = 0;
    for (int c = 0; c < 100 && n < 5; c++) begin
      step();
      if (d_ack) n++;
      if (i_ack) n = 100;
    end
    d_req = 1'b0;
    total++;
    if (n != 5) begin bad++; $display("FAIL d_only_grants: got %0d want 5", n); end
    total++;
    if (dut.dstreak_q !== 4'd0) begin bad++; $display("FAIL dstreak_d_only: got %0d want 0", dut.dstreak_q); end
    step();
    mem_auto = 1'b0;
    step();
  endtask

  task automatic test_reset_busy();
    i_req = 1'b1; i_addr = 32'h300;
    step();
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL rb_busy: got mem_req=%b want 1", mem_req); end
    rst = 1'b1; i_req = 1'b0;
    step();
    rst = 1'b0;
    total++;
    if ({mem_req, mem_we, mem_wstrb, i_ack, d_ack, d_misalign} !== 9'h0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      bad++; $display("FAIL rb_outputs: got req=%b addr=%h i_rdata=%h d_rdata=%h i_ack=%b want all 0",
                      mem_req, mem_addr, i_rdata, d_rdata, i_ack);
    end
    mem_ready_man = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ready_man = 1'b0;
    total++;
    if (i_ack !== 1'b0 || d_ack !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL rb_stale_ready: got i_ack=%b d_ack=%b req=%b want 0 0 0", i_ack, d_ack, mem_req);
    end
    i_req = 1'b1; i_addr = 32'h104;
    step();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin
      bad++; $display("FAIL rb_new_req: got req=%b addr=%h want 1 00000104", mem_req, mem_addr);
    end
    mem_ready_man = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_ready_man = 1'b0; i_req = 1'b0;
    total++;
    if (i_ack !== 1'b1 || i_rdata !== 32'h12345678) begin
      bad++; $display("FAIL rb_new_ack: got ack=%b rdata=%h want 1 12345678", i_ack, i_rdata);
    end
    step();
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_addrmode = 3'b000; d_wdata = '0; mem_rdata = '0; mem_ready_man = 1'b0; mem_auto = 1'b0;
    test_reset();
    test_fetch();
    test_stores();
    test_loads();
    test_misalign();
    test_starvation();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter and access sequencer that shares one single-ported, variable-latency memory between the instruction-fetch port and the load/store port of the RISC-V core. It handles the byte-lane work for the load/store port:
- write-strobe generation and write-data lane steering for stores;
- sign/zero extension for loads, driven by `addrmode` (funct3) from the control unit.

It sits between the core (fetch stage and the `memwrite`/`resultsrc` data path) and the memory model. The core holds its PC and writeback while a requester's `*_ack` is low.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte-address width for all ports.
- `MAX_DBURST`, 4, maximum consecutive data grants while fetch waits; range 1–15.

Ports:
- `clk`  in  1  rising-edge clock; the only clock in the block.
- `rst`  in  1  reset; **synchronous, active-high**.
- `i_req`  in  1  fetch request; held high until `i_ack`.
- `i_addr`  in  ADDR_WIDTH  fetch byte address; word-aligned.
- `i_ack`  out  1  one-cycle pulse; `i_rdata` is valid in this cycle.
- `i_rdata`  out  32  fetched word.
- `d_req`  in  1  load/store request; held high until `d_ack`.
- `d_we`  in  1  1 = store (`memwrite`), 0 = load.
- `d_addr`  in  ADDR_WIDTH  data byte address (ALU result).
- `d_addrmode`  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `d_wdata`  in  32  store data, right-aligned.
- `d_ack`  out  1  one-cycle completion pulse.
- `d_rdata`  out  32  extended load result; valid with `d_ack`.
- `d_misalign`  out  1  valid with `d_ack`; 1 = rejected access, no memory cycle was issued.
- `mem_req`  out  1  memory request; held until `mem_ready`.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  ADDR_WIDTH  word address, `{addr[ADDR_WIDTH-1:2], 2'b00}`.
- `mem_wdata`  out  32  lane-steered store data.
- `mem_wstrb`  out  4  byte strobes; 0 for reads.
- `mem_ready`  in  1  memory completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  read word.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - BUSY: memory cycle in flight.
  - RESP: ack cycle. No arbitration happens in RESP.
- FSM transitions:
  - IDLE → BUSY on grant.
  - IDLE → RESP on a rejected data access.
  - BUSY → RESP when `mem_ready`=1.
  - RESP → IDLE unconditionally.
- Arbitration in IDLE:
  - Data wins by default, because it belongs to the older instruction.
  - Fetch wins when both are requesting and `dstreak == MAX_DBURST`.
- `dstreak` is a 4-bit counter:
  - It increments on a data grant made while `i_req`=1.
  - It clears on a fetch grant, or on a data grant made while `i_req`=0.
  - It saturates at `MAX_DBURST`.
- Grant latches the selected requester's addr, we, wdata, addrmode, addr[1:0] and port ID into internal registers. Memory outputs come from these registers, so they stay stable while BUSY regardless of requester inputs.
- Misalignment check, applied to data only:
  - h/hu with addr[0]=1 → reject.
  - w with addr[1:0]≠0 → reject.
  - addrmode 011/110/111 → reject.
  - A rejected access raises `d_misalign`=1 with `d_ack` in RESP, and `d_rdata`=0.
  - Fetch addr[1:0] is ignored.
- Store steering:
  - b: wdata[7:0] replicated to all four lanes; `wstrb = 4'b0001 << addr[1:0]`.
  - h: wdata[15:0] replicated to both halves; `wstrb` = 0011 for addr[1]=0, 1100 for addr[1]=1.
  - w: wdata passed through; `wstrb` = 1111.
- Load extension:
  - Select the lane by addr[1:0] (b) or addr[1] (h).
  - b/h sign-extend; bu/hu zero-extend; w passes the word through.
- `mem_rdata` is registered into `i_rdata` or `d_rdata` on the `mem_ready` cycle. The non-selected port's rdata register holds its previous value.

## Timing
- Reset values:
  - FSM = IDLE; `dstreak` = 0.
  - Outputs `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `i_ack`, `i_rdata`, `d_ack`, `d_rdata`, `d_misalign` all = 0.
- Cycle-level sequence:
  - Cycle 0: request sampled in IDLE.
  - Cycles 1..N: `mem_req`=1 (BUSY).
  - Cycle N: `mem_ready`=1.
  - Cycle N+1: `*_ack`=1 (RESP), and `mem_req`=0.
- Minimum latency is 2 cycles from request to ack (zero wait states); each memory wait state adds 1 cycle.
- Back-to-back accesses have a minimum spacing of 3 cycles (IDLE, BUSY, RESP).
- A requester must drop its `req` or present a new request in the cycle after its ack. Because RESP never grants, the held `req` during the ack cycle cannot double-issue.
- A rejected access acks in cycle 1. No `mem_req` is issued.
- `mem_ready` outside BUSY is ignored.
- Simultaneous `i_req`/`d_req` in IDLE follows the arbitration rule above. The loser keeps waiting; it has no timeout.
- `rst` asserted in any state: next cycle FSM=IDLE, `mem_req`=0, no ack issued, `dstreak`=0. The abandoned memory cycle is dropped, and `mem_ready` seen after reset is ignored.

## Test plan
- **Fetch only:**
  - Stimulus: `i_req`=1, `i_addr`=0x100, memory ready after 1 wait state, `mem_rdata`=0x00A00093.
  - Required: `mem_addr`=0x100, `mem_wstrb`=0, `i_ack` in cycle 3 with `i_rdata`=0x00A00093.
- **Stores:**
  - Stimulus: sb with wdata=0x000000AB, addr=0x203.
  - Required: `mem_wdata`=0xABABABAB, `wstrb`=1000, `mem_addr`=0x200.
  - Stimulus: sh with wdata=0x1234, addr=0x202.
  - Required: `wdata`=0x12341234, `wstrb`=1100.
- **Loads:** `mem_rdata`=0x80FF7F01.
  - lb at addr 3 → 0xFFFFFF80.
  - lbu at addr 3 → 0x00000080.
  - lh at addr 2 → 0xFFFF80FF.
  - lhu at addr 0 → 0x00007F01.
- **Misalign:**
  - Stimulus: lw at 0x102, and separately sh at 0x101.
  - Required: `d_ack` and `d_misalign`=1 in cycle 1; `mem_req` never high.
- **Starvation:**
  - Stimulus: `d_req` and `i_req` held continuously, `MAX_DBURST`=4.
  - Required: grant order D,D,D,D,I,D,D,D,D,I.
  - Stimulus: `d_req` alone.
  - Required: `dstreak` stays 0.
- **Reset mid-BUSY:**
  - Stimulus: assert `rst` for 1 cycle while `mem_req`=1 (`mem_ready` held 0).
  - Required: next cycle `mem_req`=0, no ack, all outputs 0.
  - Then apply a new `i_req`.
  - Required: it completes normally.
